// File: rtl/bus_deser_pkg.sv
// Shared types and helpers for the serial-to-parallel bus deserializer.
// Holds the receive FSM state encoding and the bit-counter width rule.
package bus_deser_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // The bit counter needs at least one bit, even for one-bit words.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_deser_fifo2.sv
// Two-entry FIFO holding completed words until the consumer takes them.
// A write is accepted while full only if the head is popped on the same edge.
module bus_deser_fifo2 #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    cnt_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign empty   = (cnt_r == 2'd0);
  assign full    = (cnt_r == 2'd2);
  assign rd_data = mem_r[rd_ptr_r];

  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_en);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {DW{1'b0}};
      mem_r[1] <= {DW{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bus_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a bit stream,
// buffers them two deep and reports dropped words and framing errors.
module bus_deserializer
  import bus_deser_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit REQUIRE_SOF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_sof,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_valid,
  input  logic             bus_out_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int     CW        = cnt_w(WIDTH);
  localparam state_e RST_STATE = (REQUIRE_SOF != 1'b0) ? HUNT : SHIFT;

  state_e           state_r;
  state_e           state_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [CW-1:0]    bit_idx_s;
  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] word_s;
  logic             take_s;
  logic             complete_s;
  logic             ferr_set_s;
  logic             ovr_set_s;
  logic             pop_s;
  logic             empty_s;
  logic             full_s;
  logic             overrun_r;
  logic             frame_err_r;

  // Decide whether this edge takes a bit and where the FSM goes next.
  always_comb begin
    state_s    = state_r;
    take_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (ser_valid && ser_sof) begin
          take_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = HUNT;
        end
      end
      SHIFT: begin
        if (ser_valid) begin
          take_s     = 1'b1;
          ferr_set_s = ser_sof && (cnt_r != {CW{1'b0}});
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = RST_STATE;
      end
    endcase
  end

  // An SOF always restarts the word at bit 0, discarding any partial word.
  always_comb begin
    bit_idx_s = ser_sof ? {CW{1'b0}} : cnt_r;
    if (MSB_FIRST != 1'b0) begin
      pos_s = CW'(WIDTH - 1) - bit_idx_s;
    end else begin
      pos_s = bit_idx_s;
    end
    base_s = (bit_idx_s == {CW{1'b0}}) ? {WIDTH{1'b0}} : shift_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos_s == CW'(i)) begin
        word_s[i] = ser_in;
      end else begin
        word_s[i] = base_s[i];
      end
    end
    complete_s = take_s && (bit_idx_s == CW'(WIDTH - 1));
    if (complete_s) begin
      cnt_s = {CW{1'b0}};
    end else if (take_s) begin
      cnt_s = bit_idx_s + CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  assign pop_s     = !empty_s && bus_out_ready;
  assign ovr_set_s = complete_s && full_s && !pop_s;

  // FSM state, bit counter and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      cnt_r   <= {CW{1'b0}};
      shift_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (take_s) begin
        shift_r <= word_s;
      end
    end
  end

  // Sticky error flags; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (err_clr) begin
        overrun_r <= 1'b0;
      end
      if (ferr_set_s) begin
        frame_err_r <= 1'b1;
      end else if (err_clr) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  bus_deser_fifo2 #(
    .DW(WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (complete_s),
    .wr_data (word_s),
    .rd_en   (pop_s),
    .rd_data (bus_out),
    .empty   (empty_s),
    .full    (full_s)
  );

  assign bus_out_valid = !empty_s;
  assign overrun       = overrun_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_bus_deserializer.sv
// Directed bench for bus_deserializer: an MSB-first and an LSB-first instance
// share one stimulus stream and are checked against hand-computed words.
module tb_bus_deserializer;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_sof;
  logic       bus_out_ready;
  logic       err_clr;
  logic [1:0] bus_out_m;
  logic       valid_m;
  logic       overrun_m;
  logic       frame_err_m;
  logic [1:0] bus_out_l;
  logic       valid_l;
  logic       overrun_l;
  logic       frame_err_l;

  int checks;
  int failures;

  bus_deserializer #(.WIDTH(2), .MSB_FIRST(1'b1), .REQUIRE_SOF(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_sof(ser_sof), .bus_out(bus_out_m), .bus_out_valid(valid_m),
    .bus_out_ready(bus_out_ready), .overrun(overrun_m),
    .frame_err(frame_err_m), .err_clr(err_clr)
  );

  bus_deserializer #(.WIDTH(2), .MSB_FIRST(1'b0), .REQUIRE_SOF(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_sof(ser_sof), .bus_out(bus_out_l), .bus_out_valid(valid_l),
    .bus_out_ready(bus_out_ready), .overrun(overrun_l),
    .frame_err(frame_err_l), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one bit for exactly one rising edge; returns on the next negedge.
  task automatic send_bit(input logic b, input logic sof);
    ser_valid = 1'b1;
    ser_in    = b;
    ser_sof   = sof;
    @(negedge clk);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    ser_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    ser_in        = 1'b0;
    ser_valid     = 1'b0;
    ser_sof       = 1'b0;
    bus_out_ready = 1'b0;
    err_clr       = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ser_in        = 1'($urandom);
      ser_valid     = 1'($urandom);
      ser_sof       = 1'($urandom);
      bus_out_ready = 1'($urandom);
      err_clr       = 1'($urandom);
    end
    @(negedge clk);
    check_eq("rst_bus_out", 32'(bus_out_m), 32'd0);
    check_eq("rst_valid", 32'(valid_m), 32'd0);
    check_eq("rst_overrun", 32'(overrun_m), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err_m), 32'd0);
    check_eq("rst_valid_lsb", 32'(valid_l), 32'd0);
    ser_in = 1'b0; ser_valid = 1'b0; ser_sof = 1'b0;
    bus_out_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // HUNT discards bits without SOF
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("hunt_discard", 32'(valid_m), 32'd0);
    check_eq("hunt_discard_lsb", 32'(valid_l), 32'd0);

    // Basic word: sof+1 then 0
    send_bit(1'b1, 1'b1);
    check_eq("half_word_no_valid", 32'(valid_m), 32'd0);
    send_bit(1'b0, 1'b0);
    check_eq("basic_valid", 32'(valid_m), 32'd1);
    check_eq("basic_word_msb", 32'(bus_out_m), 32'd2);
    check_eq("basic_word_lsb", 32'(bus_out_l), 32'd1);
    bus_out_ready = 1'b1;
    @(negedge clk);
    bus_out_ready = 1'b0;
    check_eq("basic_pop_valid", 32'(valid_m), 32'd0);
    check_eq("basic_pop_valid_lsb", 32'(valid_l), 32'd0);

    // Overrun: 01, 10, 11 with ready low (MSB-first view)
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
    check_eq("full_no_overrun", 32'(overrun_m), 32'd0);
    check_eq("stall_head_stable", 32'(bus_out_m), 32'd1);
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    check_eq("overrun_set", 32'(overrun_m), 32'd1);
    check_eq("overrun_set_lsb", 32'(overrun_l), 32'd1);
    check_eq("overrun_head", 32'(bus_out_m), 32'd1);
    check_eq("overrun_head_lsb", 32'(bus_out_l), 32'd2);
    check_eq("overrun_no_ferr", 32'(frame_err_m), 32'd0);
    bus_out_ready = 1'b1;
    @(negedge clk);
    check_eq("drain_second_valid", 32'(valid_m), 32'd1);
    check_eq("drain_second_word", 32'(bus_out_m), 32'd2);
    @(negedge clk);
    check_eq("drain_empty", 32'(valid_m), 32'd0);
    bus_out_ready = 1'b0;
    check_eq("overrun_sticky", 32'(overrun_m), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("overrun_cleared", 32'(overrun_m), 32'd0);

    // Frame error: sof+1, sof+0, then 1
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check_eq("ferr_set", 32'(frame_err_m), 32'd1);
    check_eq("ferr_set_lsb", 32'(frame_err_l), 32'd1);
    check_eq("ferr_no_word", 32'(valid_m), 32'd0);
    send_bit(1'b1, 1'b0);
    check_eq("ferr_word_valid", 32'(valid_m), 32'd1);
    check_eq("ferr_word_msb", 32'(bus_out_m), 32'd1);
    check_eq("ferr_word_lsb", 32'(bus_out_l), 32'd2);
    bus_out_ready = 1'b1;
    @(negedge clk);
    bus_out_ready = 1'b0;

    // err_clr coinciding with a new SOF error: set wins
    send_bit(1'b1, 1'b1);
    err_clr = 1'b1;
    send_bit(1'b1, 1'b1);
    err_clr = 1'b0;
    check_eq("ferr_set_wins", 32'(frame_err_m), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("ferr_cleared", 32'(frame_err_m), 32'd0);

    // Complete the pending word, then SOF at count 0 is legal
    send_bit(1'b0, 1'b0);
    check_eq("pending_word", 32'(bus_out_m), 32'd2);
    send_bit(1'b1, 1'b1);
    check_eq("sof_at_zero_legal", 32'(frame_err_m), 32'd0);
    send_bit(1'b1, 1'b0);
    bus_out_ready = 1'b1;
    idle(3);
    bus_out_ready = 1'b0;
    check_eq("drain2_empty", 32'(valid_m), 32'd0);

    // Reset mid-operation: one buffered word plus a half word
    send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_eq("pre_reset_valid", 32'(valid_m), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_valid", 32'(valid_m), 32'd0);
    check_eq("async_reset_valid_lsb", 32'(valid_l), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send_bit(1'b1, 1'b0);
    check_eq("post_reset_hunt", 32'(valid_m), 32'd0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
    check_eq("post_reset_valid", 32'(valid_m), 32'd1);
    check_eq("post_reset_word", 32'(bus_out_m), 32'd1);
    check_eq("post_reset_word_lsb", 32'(bus_out_l), 32'd2);
    bus_out_ready = 1'b1;
    @(negedge clk);
    bus_out_ready = 1'b0;
    check_eq("post_reset_single", 32'(valid_m), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_deserializer.md
Name: bus_deserializer

Overview:
- Receiving end of a serial bit link; the matching serializer drives the other end.
- Collects WIDTH serial bits into one parallel word and presents the word on bus_out with a valid/ready handshake.
- Holds completed words in a 2-entry output buffer, so a stalled consumer tolerates one extra word.
- Sits between a single-wire pin/route and a bus-consuming instance in the top-level netlist.

Parameters:
- WIDTH, 2, bits per word; legal range is 1 or more.
- MSB_FIRST, 1, 1: first received bit lands in bus_out[WIDTH-1]; 0: first received bit lands in bus_out[0].
- REQUIRE_SOF, 1, 1: bits are ignored after reset until a start-of-frame bit arrives; 0: reception starts immediately.

Ports:
- clk  input  1  sole clock; all flops on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is sampled on this edge.
- ser_sof  input  1  qualified by ser_valid; marks the current bit as bit 0 of a new word.
- bus_out  output  WIDTH  head word of the output buffer.
- bus_out_valid  output  1  output buffer is not empty.
- bus_out_ready  input  1  consumer accepts the head word.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: an SOF arrived while a word was partially assembled.
- err_clr  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset state:
  - bus_out, bus_out_valid, overrun and frame_err are 0.
  - Shift register, bit counter and buffer are cleared.
  - State is HUNT if REQUIRE_SOF=1, otherwise SHIFT.
  - An assertion mid-word discards the partial word and all buffered words; bus_out_valid drops asynchronously.
- States:
  - HUNT: a bit with ser_valid=0 changes nothing. A bit with ser_valid=1 and ser_sof=0 is discarded. A bit with ser_valid=1 and ser_sof=1 is taken as bit 0, count=1, and the block goes to SHIFT.
  - SHIFT: each bit with ser_valid=1 is shifted in and count increments.
  - SOF in SHIFT with count!=0: frame_err=1, the partial word is discarded, and the SOF bit becomes bit 0 of a new word (count=1).
  - SOF in SHIFT with count==0: legal, no error.
- Word completion:
  - Occurs on the edge sampling bit index WIDTH-1. Count wraps to 0 and the block stays in SHIFT.
  - For WIDTH=1 every valid bit completes a word. An SOF at count 0 never sets frame_err.
- Latency: a completed word is written into the buffer on the completing edge. bus_out_valid is high in the very next cycle (1 cycle after the last bit is sampled).
- Bit order:
  - MSB_FIRST=1: bit k maps to bus_out[WIDTH-1-k].
  - MSB_FIRST=0: bit k maps to bus_out[k].
- Handshake:
  - Pop occurs when bus_out_valid && bus_out_ready.
  - bus_out is stable while valid is high and ready is low.
  - bus_out_ready while empty has no effect.
- Buffer: 2 entries, FIFO order.
  - Write and pop in the same cycle are allowed when empty, holding 1 entry, or full.
  - When full with a pop, the write is accepted.
  - A completing word while full with no pop is dropped. overrun=1; buffer contents are untouched.
- Sticky flags:
  - overrun and frame_err set and hold until err_clr.
  - If err_clr coincides with a new set event, the set wins and the flag stays 1.
- ser_valid=0 freezes the shift register and count; there is no timeout.
- Bus widths: the bit counter is $clog2(WIDTH) bits, minimum 1; no other arithmetic.

Decomposition:
- Package bus_deser_pkg:
  - state enum {HUNT, SHIFT}.
  - Function cnt_w(WIDTH) returning max(1, $clog2(WIDTH)).
- Sub-module bus_deser_fifo2: 2-entry parameterised-width FIFO.
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full.
  - Simultaneous rd/wr is supported when full.
- The top holds the FSM, shift register, counter and flags.

Test Plan:
- Reset: drive rst_n=0 with random inputs -> all outputs 0. Release, then send ser_valid=1, ser_sof=0, ser_in=1 twice -> no bus_out_valid (HUNT discards the bits).
- Basic word, WIDTH=2, MSB_FIRST=1: send sof+1, then 0 -> bus_out=2'b10 and bus_out_valid=1 in the cycle after the second bit. With ready=1, valid drops the next cycle.
- Bit order, MSB_FIRST=0: send sof+1, then 0 -> bus_out=2'b01.
- Overrun: hold ready=0 and send words 01, 10, 11 -> overrun=1, buffer holds 01 then 10. Raise ready -> 01 then 10 are output and valid drops. err_clr -> overrun=0.
- Frame error: send sof+1, sof+0, then 1 -> frame_err=1 and word=2'b01. A simultaneous err_clr and new SOF error -> frame_err stays 1.
- Reset mid-operation: with 1 buffered word and a half word, pulse rst_n low between clock edges -> bus_out_valid=0 immediately. After release the next complete word is the first one seen.
